// File: rtl/cpu_pkg.sv
// Shared types for the memory responder: opcode set, widths, FSM states.
// Imported by the interface, the RAM wrapper and the responder top.
package cpu_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 32;

    typedef enum logic [2:0] {
        OP_HLT,
        OP_SKZ,
        OP_ADD,
        OP_AND,
        OP_XOR,
        OP_LDA,
        OP_STO,
        OP_JMP
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } rsp_state_t;

    typedef enum logic [1:0] {
        K_FETCH,
        K_READ,
        K_WRITE
    } acc_kind_t;

    // True when at least two of the three request lines are high.
    function automatic logic multi_req(input logic a,
                                       input logic b,
                                       input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU core and the memory responder.
// master = core side, slave = responder side.
interface mem_responder_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              memIns_en;
    logic              memDa_en;
    logic              memDa_we;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] da_addr;
    logic [DATA_W-1:0] wr_data;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] rd_data;
    logic              ins_valid;
    logic              da_valid;
    logic              busy;
    logic              drop;

    modport master (
        output memIns_en, memDa_en, memDa_we,
        output pc_addr, da_addr, wr_data,
        input  opcode, operand, rd_data,
        input  ins_valid, da_valid, busy, drop
    );

    modport slave (
        input  memIns_en, memDa_en, memDa_we,
        input  pc_addr, da_addr, wr_data,
        output opcode, operand, rd_data,
        output ins_valid, da_valid, busy, drop
    );

endinterface

// File: rtl/ram_sp.sv
// Single-port RAM, synchronous read and write, contents never reset.
// Read data register only changes on a read access.
module ram_sp #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx;

    // Address wraps by dropping upper bits (DEPTH is a power of two).
    assign idx   = addr[IDX_W-1:0];
    assign rdata = rdata_q;

    // Array write or registered read, one access per enabled cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[idx] <= wdata;
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Three-state memory responder: IDLE samples a request, ACCESS hits the
// RAM, RESP presents the result. Losing/late requests pulse drop.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    rsp_state_t        state_q, state_d;
    acc_kind_t         kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ins_valid_q, ins_valid_d;
    logic              da_valid_q, da_valid_d;
    logic              drop_q, drop_d;
    logic [2:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] operand_q, operand_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              any_req;
    logic              ram_en;
    logic              ram_we;
    logic              resp_fetch;
    logic              resp_read;
    logic [DATA_W-1:0] ram_rdata;

    assign any_req = bus.memIns_en | bus.memDa_en | bus.memDa_we;

    // RAM is touched only in ACCESS, so a reset there blocks the write.
    assign ram_en = (state_q == ACCESS);
    assign ram_we = ram_en && (kind_q == K_WRITE);

    ram_sp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // The RAM read register carries the fresh word during RESP; the
    // hold registers take it over at RESP->IDLE so outputs stay put.
    assign resp_fetch = (state_q == RESP) && (kind_q == K_FETCH);
    assign resp_read  = (state_q == RESP) && (kind_q == K_READ);

    assign bus.opcode    = resp_fetch ? ram_rdata[DATA_W-1 -: 3]
                                      : opcode_q;
    assign bus.operand   = resp_fetch ? ram_rdata[ADDR_W-1:0]
                                      : operand_q;
    assign bus.rd_data   = resp_read  ? ram_rdata : rd_data_q;
    assign bus.ins_valid = ins_valid_q;
    assign bus.da_valid  = da_valid_q;
    assign bus.drop      = drop_q;
    assign bus.busy      = (state_q != IDLE);

    // Next-state, request arbitration, pulses and result capture.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        rd_data_d   = rd_data_q;
        ins_valid_d = 1'b0;
        da_valid_d  = 1'b0;
        drop_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    wdata_d = bus.wr_data;
                    drop_d  = multi_req(bus.memDa_we, bus.memDa_en,
                                        bus.memIns_en);
                    if (bus.memDa_we) begin
                        kind_d = K_WRITE;
                        addr_d = bus.da_addr;
                    end else if (bus.memDa_en) begin
                        kind_d = K_READ;
                        addr_d = bus.da_addr;
                    end else begin
                        kind_d = K_FETCH;
                        addr_d = bus.pc_addr;
                    end
                end
            end
            ACCESS: begin
                state_d     = RESP;
                drop_d      = any_req;
                ins_valid_d = (kind_q == K_FETCH);
                da_valid_d  = (kind_q != K_FETCH);
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = any_req;
                if (kind_q == K_FETCH) begin
                    opcode_d  = ram_rdata[DATA_W-1 -: 3];
                    operand_d = ram_rdata[ADDR_W-1:0];
                end
                if (kind_q == K_READ) begin
                    rd_data_d = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            kind_q      <= K_FETCH;
            addr_q      <= '0;
            wdata_q     <= '0;
            ins_valid_q <= 1'b0;
            da_valid_q  <= 1'b0;
            drop_q      <= 1'b0;
            opcode_q    <= '0;
            operand_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ins_valid_q <= ins_valid_d;
            da_valid_q  <= da_valid_d;
            drop_q      <= drop_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: write/read, fetch, arbitration,
// busy drops, reset abort and address truncation.
module tb_mem_responder;

    localparam int AW = 5;
    localparam int DW = 8;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic we, input logic en, input logic ins,
                         input logic [AW-1:0] pc, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd);
        bus.memDa_we  = we;
        bus.memDa_en  = en;
        bus.memIns_en = ins;
        bus.pc_addr   = pc;
        bus.da_addr   = da;
        bus.wr_data   = wd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Complete write transaction, no checks.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b1, 1'b0, 1'b0, '0, a, d);
        step();
        idle_in();
        step();
        step();
    endtask

    logic [5:0] wide_addr;

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        idle_in();
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_drop", 32'(bus.drop), 0);
        chk("rst_insv", 32'(bus.ins_valid), 0);
        chk("rst_dav", 32'(bus.da_valid), 0);
        chk("rst_opcode", 32'(bus.opcode), 0);
        chk("rst_operand", 32'(bus.operand), 0);
        chk("rst_rd", 32'(bus.rd_data), 0);
        rst = 1'b0;
        step();

        // write A5 to addr 3, then read it back
        drive(1'b1, 1'b0, 1'b0, '0, 5'd3, 8'hA5);
        step();
        chk("wr_acc_busy", 32'(bus.busy), 1);
        chk("wr_acc_dav", 32'(bus.da_valid), 0);
        chk("wr_acc_drop", 32'(bus.drop), 0);
        idle_in();
        step();
        chk("wr_resp_dav", 32'(bus.da_valid), 1);
        chk("wr_resp_rd", 32'(bus.rd_data), 0);
        chk("wr_resp_insv", 32'(bus.ins_valid), 0);
        step();
        chk("wr_idle_dav", 32'(bus.da_valid), 0);
        chk("wr_idle_busy", 32'(bus.busy), 0);
        drive(1'b0, 1'b1, 1'b0, '0, 5'd3, 8'h00);
        step();
        idle_in();
        chk("rd_acc_dav", 32'(bus.da_valid), 0);
        step();
        chk("rd_resp_dav", 32'(bus.da_valid), 1);
        chk("rd_resp_data", 32'(bus.rd_data), 32'hA5);
        step();
        chk("rd_idle_dav", 32'(bus.da_valid), 0);
        chk("rd_hold", 32'(bus.rd_data), 32'hA5);

        // preload addr 0 = 101_00111, fetch it
        do_write(5'd0, 8'hA7);
        drive(1'b0, 1'b0, 1'b1, 5'd0, '0, '0);
        step();
        idle_in();
        chk("f_acc_insv", 32'(bus.ins_valid), 0);
        step();
        chk("f_resp_insv", 32'(bus.ins_valid), 1);
        chk("f_resp_dav", 32'(bus.da_valid), 0);
        chk("f_opcode", 32'(bus.opcode), 5);
        chk("f_operand", 32'(bus.operand), 7);
        step();
        chk("f_idle_insv", 32'(bus.ins_valid), 0);
        chk("f_hold_opcode", 32'(bus.opcode), 5);
        chk("f_hold_operand", 32'(bus.operand), 7);

        // all three requests at once: write wins, one drop pulse
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 8'h3C);
        step();
        idle_in();
        chk("arb_drop", 32'(bus.drop), 1);
        step();
        chk("arb_drop_once", 32'(bus.drop), 0);
        chk("arb_dav", 32'(bus.da_valid), 1);
        chk("arb_insv", 32'(bus.ins_valid), 0);
        chk("arb_opcode", 32'(bus.opcode), 5);
        chk("arb_operand", 32'(bus.operand), 7);
        chk("arb_rd", 32'(bus.rd_data), 32'hA5);
        step();
        drive(1'b0, 1'b1, 1'b0, '0, 5'd4, '0);
        step();
        idle_in();
        step();
        chk("arb_rd_back", 32'(bus.rd_data), 32'h3C);
        step();

        // fetch addr 3, second fetch during ACCESS is dropped
        drive(1'b0, 1'b0, 1'b1, 5'd3, '0, '0);
        step();
        drive(1'b0, 1'b0, 1'b1, 5'd4, '0, '0);
        step();
        idle_in();
        chk("busy_insv", 32'(bus.ins_valid), 1);
        chk("busy_drop", 32'(bus.drop), 1);
        chk("busy_operand", 32'(bus.operand), 5);
        step();
        chk("busy_idle_insv", 32'(bus.ins_valid), 0);
        chk("busy_idle_drop", 32'(bus.drop), 0);
        step();
        chk("busy_no_second", 32'(bus.ins_valid), 0);
        chk("busy_no_busy", 32'(bus.busy), 0);
        chk("busy_operand_hold", 32'(bus.operand), 5);

        // reset during ACCESS aborts the write of FF to addr 9
        do_write(5'd9, 8'h11);
        drive(1'b1, 1'b0, 1'b0, '0, 5'd9, 8'hFF);
        step();
        chk("ab_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        idle_in();
        #1;
        chk("ab_busy", 32'(bus.busy), 0);
        chk("ab_opcode", 32'(bus.opcode), 0);
        chk("ab_operand", 32'(bus.operand), 0);
        chk("ab_rd", 32'(bus.rd_data), 0);
        chk("ab_dav", 32'(bus.da_valid), 0);
        chk("ab_drop", 32'(bus.drop), 0);
        step();
        rst = 1'b0;
        step();
        drive(1'b0, 1'b1, 1'b0, '0, 5'd9, '0);
        step();
        idle_in();
        step();
        chk("ab_rd_dav", 32'(bus.da_valid), 1);
        chk("ab_rd_old", 32'(bus.rd_data), 32'h11);
        step();

        // 6-bit address 35 truncates to 3
        wide_addr = 6'd35;
        drive(1'b0, 1'b1, 1'b0, '0, wide_addr[4:0], '0);
        step();
        idle_in();
        step();
        chk("wrap_dav", 32'(bus.da_valid), 1);
        chk("wrap_rd", 32'(bus.rd_data), 32'hA5);
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
